// File: rtl/vigna_coproc_arbiter_pkg.sv
// Shared definitions for the vigna M-extension coprocessor arbiter:
// func codes, arbiter state encoding, requester limits and index helpers.
package vigna_coproc_pkg;

   localparam int unsigned NREQ_MAX = 8;

   localparam logic [2:0] FUNC_MUL    = 3'b000;
   localparam logic [2:0] FUNC_MULH   = 3'b001;
   localparam logic [2:0] FUNC_MULHSU = 3'b010;
   localparam logic [2:0] FUNC_MULHU  = 3'b011;
   localparam logic [2:0] FUNC_DIV    = 3'b100;
   localparam logic [2:0] FUNC_DIVU   = 3'b101;
   localparam logic [2:0] FUNC_REM    = 3'b110;
   localparam logic [2:0] FUNC_REMU   = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } arb_state_e;

   typedef logic [2:0] req_idx_t;

   // One coprocessor operation as presented by a requester.
   typedef struct packed {
      logic [2:0]  func;
      logic [31:0] op1;
      logic [31:0] op2;
   } cp_op_t;

   // One-hot decode of a requester index, NREQ_MAX bits wide.
   function automatic logic [NREQ_MAX-1:0] idx_onehot(input req_idx_t idx);
      return {{(NREQ_MAX-1){1'b0}}, 1'b1} << idx;
   endfunction

endpackage

// File: rtl/vigna_coproc_arbiter_if.sv
// Bus between the arbiter (master) and the single vigna_m_ext
// coprocessor (slave): issue handshake, tagged operands and result.
interface vigna_coproc_arbiter_if;

   logic        cp_valid;
   logic        cp_ready;
   logic [2:0]  cp_func;
   logic [2:0]  cp_id;
   logic [31:0] cp_op1;
   logic [31:0] cp_op2;
   logic [31:0] cp_result;

   modport master (
      output cp_valid, cp_func, cp_id, cp_op1, cp_op2,
      input  cp_ready, cp_result
   );

   modport slave (
      input  cp_valid, cp_func, cp_id, cp_op1, cp_op2,
      output cp_ready, cp_result
   );

endinterface

// File: rtl/vigna_coproc_arbiter_rr_pick.sv
// Combinational round-robin picker: the first asserted request found
// searching upward from last+1 (mod NREQ) wins.
module vigna_rr_pick
   import vigna_coproc_pkg::*;
#(
   parameter int unsigned NREQ = 2
) (
   input  logic [NREQ-1:0] req,
   input  req_idx_t        last,
   output logic            any,
   output req_idx_t        idx
);

   int unsigned     cand;
   logic [NREQ-1:0] rot;

   // Walk the candidates in priority order, keep the first hit.
   always_comb begin
      any  = 1'b0;
      idx  = '0;
      cand = 0;
      rot  = '0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         cand = (32'(last) + k) % NREQ;
         rot  = req >> cand;
         if (!any && rot[0]) begin
            any = 1'b1;
            idx = req_idx_t'(cand);
         end
      end
   end

endmodule

// File: rtl/vigna_coproc_arbiter.sv
// Shares one vigna_m_ext coprocessor between NREQ requesters with a
// round-robin grant and one operation in flight. Operands are held on
// the coprocessor bus for the whole operation, and the result returns
// to the granted requester as a one-cycle req_ready pulse.
// Optional feature macro: VIGNA_COPROC_ARB_REUSE_EN adds a one-entry
// result cache that answers exact repeats without touching the coprocessor.
module vigna_coproc_arbiter
   import vigna_coproc_pkg::*;
#(
   parameter int unsigned NREQ = 2
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic [NREQ-1:0]        req_valid,
   input  logic [3*NREQ-1:0]      req_func,
   input  logic [32*NREQ-1:0]     req_op1,
   input  logic [32*NREQ-1:0]     req_op2,
   output logic [NREQ-1:0]        req_ready,
   output logic [32*NREQ-1:0]     req_result,
   vigna_coproc_arbiter_if.master cp
);

   arb_state_e        state_q;
   req_idx_t          gnt_q;
   req_idx_t          last_q;
   logic              cp_valid_q;
   cp_op_t            cp_op_q;
   req_idx_t          cp_id_q;
   logic [NREQ-1:0]   req_ready_q;
   logic [32*NREQ-1:0] req_result_q;

   logic              pick_any;
   req_idx_t          pick_idx;
   cp_op_t            win_op;

   vigna_rr_pick #(
      .NREQ (NREQ)
   ) u_pick (
      .req  (req_valid),
      .last (last_q),
      .any  (pick_any),
      .idx  (pick_idx)
   );

   // Slice the winning requester's operation out of the flat buses.
   always_comb begin
      win_op = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (req_idx_t'(i) == pick_idx) begin
            win_op.func = req_func[3*i +: 3];
            win_op.op1  = req_op1[32*i +: 32];
            win_op.op2  = req_op2[32*i +: 32];
         end
      end
   end

`ifdef VIGNA_COPROC_ARB_REUSE_EN
   logic        cache_valid_q;
   cp_op_t      cache_op_q;
   logic [31:0] cache_result_q;
   logic        cache_hit;

   assign cache_hit = cache_valid_q && (win_op == cache_op_q);
`endif

   // Arbiter FSM: grant in IDLE, hold operands in BUSY, one quiet DONE cycle.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q      <= ST_IDLE;
         gnt_q        <= '0;
         last_q       <= req_idx_t'(NREQ - 1);
         cp_valid_q   <= 1'b0;
         cp_op_q      <= '0;
         cp_id_q      <= '0;
         req_ready_q  <= '0;
         req_result_q <= '0;
`ifdef VIGNA_COPROC_ARB_REUSE_EN
         cache_valid_q  <= 1'b0;
         cache_op_q     <= '0;
         cache_result_q <= '0;
`endif
      end else begin
         req_ready_q <= '0;
         case (state_q)
            ST_IDLE: begin
               if (pick_any) begin
                  gnt_q  <= pick_idx;
                  last_q <= pick_idx;
`ifdef VIGNA_COPROC_ARB_REUSE_EN
                  // A hit skips BUSY entirely; DONE then carries the pulse.
                  if (cache_hit) begin
                     for (int unsigned i = 0; i < NREQ; i++) begin
                        if (req_idx_t'(i) == pick_idx) begin
                           req_result_q[32*i +: 32] <= cache_result_q;
                        end
                     end
                     req_ready_q <= NREQ'(idx_onehot(pick_idx));
                     state_q     <= ST_DONE;
                  end else begin
                     cp_op_q    <= win_op;
                     cp_id_q    <= pick_idx;
                     cp_valid_q <= 1'b1;
                     state_q    <= ST_BUSY;
                  end
`else
                  cp_op_q    <= win_op;
                  cp_id_q    <= pick_idx;
                  cp_valid_q <= 1'b1;
                  state_q    <= ST_BUSY;
`endif
               end
            end
            ST_BUSY: begin
               if (cp.cp_ready) begin
                  for (int unsigned i = 0; i < NREQ; i++) begin
                     if (req_idx_t'(i) == gnt_q) begin
                        req_result_q[32*i +: 32] <= cp.cp_result;
                     end
                  end
                  req_ready_q <= NREQ'(idx_onehot(gnt_q));
                  cp_valid_q  <= 1'b0;
`ifdef VIGNA_COPROC_ARB_REUSE_EN
                  cache_valid_q  <= 1'b1;
                  cache_op_q     <= cp_op_q;
                  cache_result_q <= cp.cp_result;
`endif
                  state_q <= ST_DONE;
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign cp.cp_valid = cp_valid_q;
   assign cp.cp_func  = cp_op_q.func;
   assign cp.cp_id    = cp_id_q;
   assign cp.cp_op1   = cp_op_q.op1;
   assign cp.cp_op2   = cp_op_q.op2;
   assign req_ready   = req_ready_q;
   assign req_result  = req_result_q;

endmodule

// File: tb/tb_vigna_coproc_arbiter.sv
// Directed bench for vigna_coproc_arbiter with NREQ=3, a behavioural
// M-extension coprocessor with programmable latency, and a scoreboard of
// expected {requester, result} completions in grant order.
module tb_vigna_coproc_arbiter;
   import vigna_coproc_pkg::*;

   localparam int unsigned NREQ = 3;

   logic                 clk = 1'b0;
   logic                 resetn = 1'b0;
   logic [NREQ-1:0]      req_valid = '0;
   logic [3*NREQ-1:0]    req_func = '0;
   logic [32*NREQ-1:0]   req_op1 = '0;
   logic [32*NREQ-1:0]   req_op2 = '0;
   logic [NREQ-1:0]      req_ready;
   logic [32*NREQ-1:0]   req_result;

   vigna_coproc_arbiter_if cp_if ();

   vigna_coproc_arbiter #(.NREQ(NREQ)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .req_valid  (req_valid),
      .req_func   (req_func),
      .req_op1    (req_op1),
      .req_op2    (req_op2),
      .req_ready  (req_ready),
      .req_result (req_result),
      .cp         (cp_if.master)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int m_lat = 3;
   int m_issues = 0;

   typedef struct packed {
      logic [2:0]  id;
      logic [31:0] res;
   } exp_t;
   exp_t exp_q[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mext(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sa, sb;
      logic [63:0] ua, ub, p;
      logic [31:0] r;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      ua = {32'd0, a};
      ub = {32'd0, b};
      r  = '0;
      case (f)
         FUNC_MUL:    begin p = ua * ub; r = p[31:0]; end
         FUNC_MULH:   begin p = sa * sb; r = p[63:32]; end
         FUNC_MULHSU: begin p = sa * $signed(ub); r = p[63:32]; end
         FUNC_MULHU:  begin p = ua * ub; r = p[63:32]; end
         FUNC_DIV:    if (b == 0) r = '1; else r = $signed(a) / $signed(b);
         FUNC_DIVU:   if (b == 0) r = '1; else r = a / b;
         FUNC_REM:    if (b == 0) r = a;  else r = $signed(a) % $signed(b);
         default:     if (b == 0) r = a;  else r = a % b;
      endcase
      return r;
   endfunction

   task automatic set_req(input int i, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      req_valid[i]        = 1'b1;
      req_func[3*i +: 3]  = f;
      req_op1[32*i +: 32] = a;
      req_op2[32*i +: 32] = b;
   endtask

   task automatic push(input int i, input logic [31:0] r);
      exp_t e;
      e.id  = 3'(i);
      e.res = r;
      exp_q.push_back(e);
   endtask

   task automatic wait_ready(input int i, input string tag);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (req_ready[i] !== 1'b1 && n < 200);
      chk(tag, {63'd0, req_ready[i]}, 64'd1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      resetn    = 1'b0;
      req_valid = '0;
      @(negedge clk);
      @(negedge clk);
      resetn = 1'b1;
   endtask

   // Behavioural coprocessor: sample an issue, answer after m_lat edges.
   initial begin
      logic [2:0]  f;
      logic [31:0] a, b;
      bit          abort;
      cp_if.cp_ready  = 1'b0;
      cp_if.cp_result = '0;
      forever begin
         @(posedge clk);
         #1;
         if (resetn && cp_if.cp_valid) begin
            f = cp_if.cp_func;
            a = cp_if.cp_op1;
            b = cp_if.cp_op2;
            m_issues++;
            abort = 1'b0;
            for (int k = 0; k < m_lat; k++) begin
               @(posedge clk);
               #1;
               if (!resetn) begin
                  abort = 1'b1;
                  break;
               end
            end
            if (!abort) begin
               cp_if.cp_ready  = 1'b1;
               cp_if.cp_result = mext(f, a, b);
               @(posedge clk);
               #1;
               cp_if.cp_ready = 1'b0;
            end
         end
      end
   end

   // Scoreboard consumer: every completion pulse is checked against the queue.
   always @(negedge clk) begin
      exp_t e;
      if (resetn && req_ready != '0) begin
         chk("ready_onehot", {63'd0, $onehot(req_ready)}, 64'd1);
         chk("cpv_low_at_ready", {63'd0, cp_if.cp_valid}, 64'd0);
         if (exp_q.size() == 0) begin
            chk("unexpected_ready", 64'(req_ready), 64'd0);
         end else begin
            e = exp_q.pop_front();
            chk("ready_id", 64'(req_ready), 64'(NREQ'(1) << e.id));
            chk("result", 64'(req_result[32*e.id +: 32]), 64'(e.res));
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  n;
      int  seen;
      int  iss;
      bit  held_ok;
      bit  any_ready;

      // Reset values
      repeat (2) @(negedge clk);
      chk("rst_cp_valid", {63'd0, cp_if.cp_valid}, 64'd0);
      chk("rst_cp_id_func", {58'd0, cp_if.cp_id, cp_if.cp_func}, 64'd0);
      chk("rst_cp_ops", {cp_if.cp_op1, cp_if.cp_op2}, 64'd0);
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_req_result", {63'd0, (req_result == '0)}, 64'd1);
      resetn = 1'b1;

      // Single requester MUL 7*6
      m_lat = 3;
      set_req(0, FUNC_MUL, 32'd7, 32'd6);
      push(0, 32'd42);
      @(negedge clk);
      chk("t1_cp_valid", {63'd0, cp_if.cp_valid}, 64'd1);
      chk("t1_cp_id", 64'(cp_if.cp_id), 64'd0);
      chk("t1_cp_func", 64'(cp_if.cp_func), 64'(FUNC_MUL));
      chk("t1_cp_ops", {cp_if.cp_op1, cp_if.cp_op2}, {32'd7, 32'd6});
      n = 0;
      while (cp_if.cp_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("t1_cp_ready_seen", {63'd0, cp_if.cp_ready}, 64'd1);
      chk("t1_cpv_held", {63'd0, cp_if.cp_valid}, 64'd1);
      @(negedge clk);
      chk("t1_req_ready", 64'(req_ready), 64'd1);
      chk("t1_cpv_low", {63'd0, cp_if.cp_valid}, 64'd0);
      chk("t1_result", 64'(req_result[31:0]), 64'd42);
      req_valid[0] = 1'b0;
      @(negedge clk);
      chk("t1_ready_drop", 64'(req_ready), 64'd0);

      // Simultaneous requests from reset: 0 first, then 1
      do_reset();
      set_req(0, FUNC_DIVU, 32'd100, 32'd7);
      set_req(1, FUNC_REMU, 32'd100, 32'd7);
      push(0, 32'd14);
      push(1, 32'd2);
      wait_ready(0, "t2_first_ready");
      req_valid[0] = 1'b0;
      wait_ready(1, "t2_second_ready");
      req_valid[1] = 1'b0;

      // Three requesters held continuously
      do_reset();
      m_lat = 2;
      for (int i = 0; i < 3; i++) set_req(i, FUNC_MULHU, 32'hFFFF_FFFF, 32'd2);
      for (int r = 0; r < 2; r++)
         for (int i = 0; i < 3; i++) push(i, 32'd1);
      seen = 0;
      n    = 0;
      while (seen < 6 && n < 400) begin
         @(negedge clk);
         n++;
         if (req_ready != '0) seen++;
      end
      req_valid = '0;
      chk("t3_pulses", 64'(seen), 64'd6);

      // Late request from 1 during 0's BUSY
      @(negedge clk);
      m_lat = 4;
      set_req(0, FUNC_MUL, 32'd11, 32'd13);
      push(0, 32'd143);
      @(negedge clk);
      @(negedge clk);
      chk("t4_grant0_id", 64'(cp_if.cp_id), 64'd0);
      set_req(1, FUNC_DIV, 32'hFFFF_FFEC, 32'd3);
      push(1, 32'hFFFF_FFFA);
      held_ok = 1'b1;
      n = 0;
      while (req_ready[0] !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
         if (cp_if.cp_op1 !== 32'd11 || cp_if.cp_op2 !== 32'd13 ||
             cp_if.cp_id !== 3'd0 || cp_if.cp_func !== FUNC_MUL)
            held_ok = 1'b0;
      end
      chk("t4_ops_held", {63'd0, held_ok}, 64'd1);
      chk("t4_ready0", {63'd0, req_ready[0]}, 64'd1);
      req_valid[0] = 1'b0;
      @(negedge clk);
      chk("t4_done_no_grant", {63'd0, cp_if.cp_valid}, 64'd0);
      @(negedge clk);
      chk("t4_grant1_valid", {63'd0, cp_if.cp_valid}, 64'd1);
      chk("t4_grant1_id", 64'(cp_if.cp_id), 64'd1);
      chk("t4_grant1_op1", 64'(cp_if.cp_op1), 64'h0000_0000_FFFF_FFEC);
      wait_ready(1, "t4_ready1");
      req_valid[1] = 1'b0;

      // Reset during BUSY
      @(negedge clk);
      m_lat = 5;
      set_req(0, FUNC_MUL, 32'd3, 32'd4);
      n = 0;
      while (cp_if.cp_valid !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("t5_issued", {63'd0, cp_if.cp_valid}, 64'd1);
      @(negedge clk);
      resetn    = 1'b0;
      req_valid = '0;
      @(negedge clk);
      chk("t5_rst_cp_valid", {63'd0, cp_if.cp_valid}, 64'd0);
      chk("t5_rst_cp_id_func", {58'd0, cp_if.cp_id, cp_if.cp_func}, 64'd0);
      chk("t5_rst_cp_ops", {cp_if.cp_op1, cp_if.cp_op2}, 64'd0);
      chk("t5_rst_req_ready", 64'(req_ready), 64'd0);
      chk("t5_rst_req_result", {63'd0, (req_result == '0)}, 64'd1);
      resetn = 1'b1;
      any_ready = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (req_ready != '0) any_ready = 1'b1;
      end
      chk("t5_no_ready_after_reset", {63'd0, any_ready}, 64'd0);
      set_req(0, FUNC_MUL, 32'd3, 32'd5);
      push(0, 32'd15);
      wait_ready(0, "t5_fresh_ready");
      req_valid[0] = 1'b0;

`ifdef VIGNA_COPROC_ARB_REUSE_EN
      // Result reuse on an exact repeat
      do_reset();
      m_lat = 3;
      set_req(0, FUNC_MUL, 32'd9, 32'd9);
      push(0, 32'd81);
      wait_ready(0, "t6_first_ready");
      req_valid[0] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      iss = m_issues;
      set_req(0, FUNC_MUL, 32'd9, 32'd9);
      push(0, 32'd81);
      @(negedge clk);
      chk("t6_hit_ready", {63'd0, req_ready[0]}, 64'd1);
      chk("t6_hit_cpv", {63'd0, cp_if.cp_valid}, 64'd0);
      chk("t6_hit_result", 64'(req_result[31:0]), 64'd81);
      chk("t6_hit_no_issue", 64'(m_issues), 64'(iss));
      req_valid[0] = 1'b0;
      @(negedge clk);
      set_req(0, FUNC_MUL, 32'd9, 32'd8);
      push(0, 32'd72);
      wait_ready(0, "t6_miss_ready");
      chk("t6_miss_issued", 64'(m_issues), 64'(iss + 1));
      req_valid[0] = 1'b0;
`else
      iss = 0;
`endif

      repeat (3) @(negedge clk);
      chk("sb_drained", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/vigna_coproc_arbiter.md
# vigna_coproc_arbiter

Shares one `vigna_m_ext` multiply/divide coprocessor between up to 8 requesters, e.g. two vigna cores or a core plus a DMA checksum engine. Round-robin grant, one operation in flight. The block holds operands and func stable to the coprocessor for the full operation, tags each issue with the requester index on `id`, and routes the latched result back as a one-cycle `req_ready` pulse. It sits between the requester execute stages and the single `vigna_m_ext` instance.

## Interface
- `NREQ`, default 2: number of requesters, legal 2..8.
- `clk`  in  1: clock.
- `resetn`  in  1: reset, synchronous, active-low; clock `clk`.
- `req_valid`  in  NREQ: per-requester request. Must be held with operands stable until `req_ready` pulses.
- `req_func`  in  3*NREQ: per-requester M-ext func (000 MUL … 111 REMU), slice `[3i+2:3i]`.
- `req_op1`  in  32*NREQ: per-requester rs1 value.
- `req_op2`  in  32*NREQ: per-requester rs2 value.
- `req_ready`  out  NREQ: one-cycle completion pulse, one-hot or zero.
- `req_result`  out  32*NREQ: per-requester result. Holds its value until that requester's next completion.
- `cp_valid`  out  1: coprocessor valid.
- `cp_ready`  in  1: coprocessor ready pulse.
- `cp_func`  out  3: coprocessor func.
- `cp_id`  out  3: granted requester index.
- `cp_op1`  out  32: coprocessor op1.
- `cp_op2`  out  32: coprocessor op2.
- `cp_result`  in  32: coprocessor result.

## Operation
- FSM states and transitions:
  - IDLE → BUSY on a grant.
  - BUSY → DONE on `cp_ready`.
  - DONE → IDLE unconditionally.
- **IDLE**
  - Round-robin pick among asserted `req_valid`. Search starts at `last+1` mod NREQ.
  - On a grant: register winner index into `gnt` and `last`. Copy the winner's func, op1 and op2 into the `cp_*` registers. Set `cp_valid`=1.
- **BUSY**
  - `cp_*` outputs held constant.
  - On `cp_ready`=1: latch `cp_result` into `req_result[gnt]`, clear `cp_valid`, set `req_ready[gnt]`=1, go to DONE.
- **DONE**
  - `req_ready` drops, no grant is made; this cycle lets the coprocessor return to its idle state.
- Requester rule: on the edge where it sees `req_ready`, the requester either deasserts `req_valid` or presents a new operation. A `req_valid` still high when the arbiter is back in IDLE is a new request.
- `req_valid` from non-granted requesters is ignored until IDLE. Requests are never dropped, only deferred.
- `cp_ready` outside BUSY is ignored.
- Reset mid-operation: all state cleared. The in-flight op is lost and no `req_ready` is produced. The coprocessor shares `resetn`.
- Reset values:
  - `cp_valid`, `cp_func`, `cp_id`, `cp_op1`, `cp_op2`, `req_ready`, `req_result`: 0.
  - FSM in IDLE.
  - `last` = NREQ-1, so requester 0 wins the first tie.

## Timing
- Edge T grants. `cp_valid` is high from T.
- Coprocessor latency L = edges from T until `cp_ready` is high.
- `req_ready` is high in the cycle after `cp_ready`. Arbiter overhead is one cycle in front (grant) and one behind (delivery).
- `cp_valid` goes low on the same edge that raises `req_ready`. The coprocessor therefore samples `cp_valid`=0 when it returns to idle, and no double issue occurs.
- Minimum grant-to-grant spacing is L+3 edges (BUSY exit, DONE, IDLE).
- `req_ready` and `cp_valid` are purely registered; no combinational path from any input to any output.

## Configuration
- `VIGNA_COPROC_ARB_REUSE_EN` defined:
  - A one-entry cache {valid, func, op1, op2, result} is updated at every BUSY completion.
  - In IDLE, if the winner's {func, op1, op2} exactly matches a valid entry, the arbiter goes directly to DONE. It pulses `req_ready` with the cached result the next cycle; `cp_valid` is never raised.
  - The cache is cleared by reset.
- `VIGNA_COPROC_ARB_REUSE_EN` undefined: no cache logic; every request is issued to the coprocessor.

## Structure
- Package `vigna_coproc_pkg` holds:
  - M-ext func code constants (FUNC_MUL … FUNC_REMU).
  - Arbiter state encoding (ST_IDLE, ST_BUSY, ST_DONE).
  - NREQ_MAX = 8.
- One combinational sub-module `vigna_rr_pick`, parameter NREQ:
  - Inputs: request vector and `last`.
  - Outputs: `any` and winner index.
- Slicing, latching and the optional cache stay in the top.

## Test plan
- Single requester 0, MUL op1=7, op2=6 → `cp_valid` high from the grant edge, `cp_id`=0. `req_ready[0]` one cycle after `cp_ready`, `req_result[0]`=42, `cp_valid` low the same cycle.
- Requesters 0 and 1 both assert on the same edge from reset, 0: DIVU 100/7, 1: REMU 100/7 → 0 served first (result 14), then 1 (result 2). No overlap in `cp_valid`.
- All three of NREQ=3 held continuously with MULHU 0xFFFFFFFF×2 → grant order 0,1,2,0,…; every result=1; `req_ready` is never two-hot.
- Requester 1 asserts mid-BUSY of requester 0 → `cp_op*` unchanged until 0's `req_ready`. Requester 1 is granted in the IDLE cycle after DONE.
- `resetn` low for one edge during BUSY → all outputs 0 and no `req_ready`. A fresh MUL 3×5 afterwards returns 15.
- `VIGNA_COPROC_ARB_REUSE_EN` defined, MUL 9×9 issued twice → second `req_ready` one cycle after its grant with result 81 and no `cp_valid`. Changing op2 to 8 forces issue, result 72.
